// File: rtl/opn_bus_pkg.sv
// Shared constants and types for the OPN host-bus responder.
// Status bit positions, default sizes and the FIFO entry layout.
package opn_bus_pkg;

    localparam int BUSY_BIT = 7;
    localparam int OVF_BIT  = 2;
    localparam int TB_BIT   = 1;
    localparam int TA_BIT   = 0;

    localparam int DEF_BUSY_CYCLES = 32;
    localparam int DEF_DEPTH       = 4;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);

    typedef enum logic {
        NO_ADDR,
        ADDR_OK
    } addr_state_e;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] val;
    } wr_entry_t;

endpackage

// File: rtl/opn_wr_fifo.sv
// Register-write FIFO holding {sel,val} pairs.
// A pop in the same cycle frees a slot for a push into a full FIFO.
module opn_wr_fifo
    import opn_bus_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  wr_entry_t data_i,
    input  logic      pop_i,
    output wr_entry_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    wr_entry_t     mem_q [DEPTH];

    logic do_pop, do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/opn_bus_responder.sv
// Chip-side OPN host bus responder: stroke decode, write FIFO,
// paced register-write drain and status readback.
module opn_bus_responder
    import opn_bus_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       addr,
    input  logic [7:0] din,
    input  logic [1:0] timer_flags,
    input  logic       reg_ready,
    output logic [7:0] dout,
    output logic       reg_we,
    output logic [7:0] reg_sel,
    output logic [7:0] reg_val,
    output logic       busy
);

    localparam int TW = $clog2(BUSY_CYCLES + 1);

    addr_state_e state_q, state_d;
    logic [7:0]  sel_q, sel_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic        ovf_q, ovf_d;
    logic        wr_n_q, rd_n_q;
    logic [7:0]  dout_q, dout_d;
    logic        we_q;
    logic [7:0]  rsel_q, rval_q;

    logic      wr_stb, rd_stb;
    logic      push_req, push_acc, pop;
    logic      full, empty;
    wr_entry_t push_data, head;

    assign wr_stb = ~cs_n & ~wr_n & wr_n_q;
    assign rd_stb = ~cs_n & ~rd_n & rd_n_q;

    assign push_req  = wr_stb & addr & (state_q == ADDR_OK);
    assign pop       = ~empty & cen & reg_ready;
    assign push_acc  = push_req & (~full | pop);
    assign push_data = '{sel: sel_q, val: din};

    assign busy = (tmr_q != '0) | full;

    opn_wr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_in),
        .rst_i  (rst),
        .push_i (push_req),
        .data_i (push_data),
        .pop_i  (pop),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tmr_d   = tmr_q;
        ovf_d   = ovf_q;
        dout_d  = dout_q;
        if (wr_stb && !addr) begin
            sel_d   = din;
            state_d = ADDR_OK;
        end
        if (push_acc) begin
            tmr_d = TW'(BUSY_CYCLES);
        end else if (cen && tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
        end
        // Read sees pre-update status; an overflow in the same cycle wins.
        if (rd_stb) begin
            dout_d = {busy, 4'b0, ovf_q, timer_flags};
            ovf_d  = 1'b0;
        end
        if (push_req && !push_acc) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= NO_ADDR;
            sel_q   <= '0;
            tmr_q   <= '0;
            ovf_q   <= 1'b0;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            dout_q  <= '0;
            we_q    <= 1'b0;
            rsel_q  <= '0;
            rval_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tmr_q   <= tmr_d;
            ovf_q   <= ovf_d;
            wr_n_q  <= wr_n;
            rd_n_q  <= rd_n;
            dout_q  <= dout_d;
            we_q    <= pop;
            if (pop) begin
                rsel_q <= head.sel;
                rval_q <= head.val;
            end
        end
    end

    assign dout    = dout_q;
    assign reg_we  = we_q;
    assign reg_sel = rsel_q;
    assign reg_val = rval_q;

endmodule

// File: tb/tb_opn_bus_responder.sv
// Directed bench for opn_bus_responder with a register-write
// scoreboard checked on every reg_we strobe.
module tb_opn_bus_responder;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       addr = 1'b0;
    logic [7:0] din = '0;
    logic [1:0] timer_flags = '0;
    logic       reg_ready = 1'b1;
    logic [7:0] dout;
    logic       reg_we;
    logic [7:0] reg_sel;
    logic [7:0] reg_val;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [15:0] sb[$];

    opn_bus_responder #(
        .DEPTH(4),
        .BUSY_CYCLES(32)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .cen        (cen),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .addr       (addr),
        .din        (din),
        .timer_flags(timer_flags),
        .reg_ready  (reg_ready),
        .dout       (dout),
        .reg_we     (reg_we),
        .reg_sel    (reg_sel),
        .reg_val    (reg_val),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk_in) begin
        if (reg_we === 1'b1) begin
            logic [15:0] e;
            we_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_reg_we", {reg_sel, reg_val}, 16'hxxxx);
            end else begin
                e = sb.pop_front();
                chk("reg_write", {reg_sel, reg_val}, e);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk_in);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(negedge clk_in);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic rd(output logic [7:0] v);
        @(negedge clk_in);
        cs_n = 1'b0; rd_n = 1'b0;
        @(negedge clk_in);
        cs_n = 1'b1; rd_n = 1'b1;
        v = dout;
    endtask

    initial begin
        logic [7:0] v;
        int base;
        int bcnt;

        repeat (2) @(negedge clk_in);
        chk("rst_dout", 16'(dout), 16'h00);
        chk("rst_we", 16'(reg_we), 16'h0);
        chk("rst_sel", 16'(reg_sel), 16'h00);
        chk("rst_val", 16'(reg_val), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;

        // 1: latency and single strobe
        base = we_cnt;
        wr(1'b0, 8'hB0);
        @(negedge clk_in);
        cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h07;
        sb.push_back(16'hB007);
        @(negedge clk_in);
        cs_n = 1'b1; wr_n = 1'b1;
        chk("t1_we_T1", 16'(reg_we), 16'h0);
        @(negedge clk_in);
        chk("t1_we_T2", 16'(reg_we), 16'h1);
        @(negedge clk_in);
        chk("t1_we_T3", 16'(reg_we), 16'h0);
        chk("t1_sel_hold", {reg_sel, reg_val}, 16'hB007);
        repeat (4) @(negedge clk_in);
        chk("t1_count", 16'(we_cnt - base), 16'd1);

        // 2: data with no address
        do_reset();
        base = we_cnt;
        wr(1'b1, 8'h24);
        repeat (5) @(negedge clk_in);
        chk("t2_no_we", 16'(we_cnt - base), 16'd0);
        chk("t2_busy", 16'(busy), 16'h0);
        rd(v);
        chk("t2_status", 16'(v), 16'h00);

        // 3: overflow and ordering
        do_reset();
        reg_ready = 1'b0;
        base = we_cnt;
        wr(1'b0, 8'h40);
        for (int i = 0; i < 6; i++) begin
            wr(1'b1, 8'(i));
            if (i < 4) sb.push_back({8'h40, 8'(i)});
        end
        chk("t3_busy", 16'(busy), 16'h1);
        rd(v);
        chk("t3_rd1", 16'(v), 16'h84);
        rd(v);
        chk("t3_rd2", 16'(v), 16'h80);
        chk("t3_held", 16'(we_cnt - base), 16'd0);
        reg_ready = 1'b1;
        repeat (10) @(negedge clk_in);
        chk("t3_drained", 16'(we_cnt - base), 16'd4);
        chk("t3_sb_empty", 16'(sb.size()), 16'd0);

        // 4: long wr_n low is one stroke
        do_reset();
        base = we_cnt;
        wr(1'b0, 8'h11);
        @(negedge clk_in);
        cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h22;
        sb.push_back(16'h1122);
        repeat (10) @(negedge clk_in);
        cs_n = 1'b1; wr_n = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("t4_one_we", 16'(we_cnt - base), 16'd1);

        // 5: busy timer paced by cen every 4th cycle
        do_reset();
        timer_flags = 2'b11;
        cen = 1'b0;
        wr(1'b0, 8'h55);
        wr(1'b1, 8'h66);
        sb.push_back(16'h5566);
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (busy === 1'b1) bcnt++;
            if (i == 41) begin
                cs_n = 1'b1; rd_n = 1'b1;
                chk("t5_rd_busy", 16'(dout), 16'h83);
            end
            if (i == 40) begin
                cs_n = 1'b0; rd_n = 1'b0;
            end
            cen = (i % 4 == 3);
        end
        chk("t5_busy_len_lo", 16'(bcnt >= 127), 16'h1);
        chk("t5_busy_len_hi", 16'(bcnt <= 129), 16'h1);
        chk("t5_busy_end", 16'(busy), 16'h0);
        rd(v);
        chk("t5_rd_idle", 16'(v), 16'h03);
        chk("t5_sb_empty", 16'(sb.size()), 16'd0);
        cen = 1'b1;
        timer_flags = 2'b00;

        // 6: reset discards queued writes
        do_reset();
        reg_ready = 1'b0;
        wr(1'b0, 8'h20);
        for (int i = 0; i < 3; i++) wr(1'b1, 8'(8'h30 + i));
        rd(v);
        chk("t6_pre_rd", 16'(v), 16'h80);
        base = we_cnt;
        @(negedge clk_in);
        rst = 1'b1;
        reg_ready = 1'b1;
        @(negedge clk_in);
        chk("t6_busy", 16'(busy), 16'h0);
        chk("t6_dout", 16'(dout), 16'h00);
        chk("t6_we", 16'(reg_we), 16'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("t6_no_we", 16'(we_cnt - base), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
